multi_port_memory: RTL
======================

Name: multi_port_memory

Overview:
Parametrised successor to the single-requester temporary memory behind the core. It arbitrates N requester ports (cores or DMA) onto one word-organised RAM with programmable access latency. Each port uses the same enable/value/response handshake the core already drives. It sits between one or more Core instances and the backing store in the processor top level.

Parameters:
NUM_PORTS, 2, number of requester ports (1..8)
ADDR_WIDTH, 32, byte-address width per port
DATA_WIDTH, 32, data word width
DEPTH_LOG2, 10, log2 of RAM depth in words
LATENCY, 2, wait cycles between grant and array access (>=1)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
mem_addr  input  NUM_PORTS*ADDR_WIDTH  per-port byte address; port p in slice [p*ADDR_WIDTH +: ADDR_WIDTH]
mem_write_en  input  NUM_PORTS  per-port write request
mem_read_en  input  NUM_PORTS  per-port read request
mem_write_val  input  NUM_PORTS*DATA_WIDTH  per-port write data
mem_read_val  output  NUM_PORTS*DATA_WIDTH  per-port read data, registered
mem_response  output  NUM_PORTS  per-port one-cycle completion pulse
busy  output  1  high whenever FSM is not IDLE

Behaviour:
- Reset (reset=0, asynchronous): FSM to IDLE; mem_response=0; every mem_read_val=0; busy=0; round-robin pointer set so that port 0 has highest priority; latched request state cleared. RAM contents are not reset.
- Reset mid-transaction: the transaction is abandoned and produces no response. A write that has not reached the array-access edge is not performed.
- Request: port p requests while mem_read_en[p] | mem_write_en[p]. The requester holds addr, enables and write data stable until it sees mem_response[p], then deasserts the enables in the following cycle.
- Read and write both asserted on one port: write is performed. mem_read_val returns the pre-write word (read-before-write).
- Addressing: word index = addr[DEPTH_LOG2+1:2]. Bits [1:0] are ignored. Upper bits are ignored, so out-of-range addresses alias (wrap).
- FSM:
  - IDLE: if any port requests, grant by round-robin starting at the port after the last granted. Latch port index, address, write enable and write data. Load cnt=LATENCY-1 and go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: if cnt!=0, decrement. If cnt==0, perform the array op (write RAM, or capture the RAM word into the read register) and go to RESPOND.
  - RESPOND: mem_response[grant]=1 for exactly this cycle. mem_read_val[grant] is updated in this cycle for reads and read+write; it is unchanged for pure writes. Update the round-robin pointer to grant, then go to IDLE.
- Timing: request sampled in IDLE at edge T produces a response visible in cycle T+LATENCY+1. Throughput is one transaction per LATENCY+2 cycles.
- mem_read_val[p] holds its last value until port p's next read response. Other ports' outputs never change on a grant to p.
- Only one mem_response bit is high in any cycle.
- A request still asserted in the IDLE cycle after its response is treated as a new transaction. The bench must check requesters deassert.
- Requests arriving while busy wait; none are dropped.
- Fairness: with all ports continuously requesting, each port is granted once every NUM_PORTS transactions.
- NUM_PORTS=1 degenerates to a latency-configurable single-port memory; the arbiter is trivial.

Test Plan:
- Single write then read, port 0, LATENCY=2: write 0xDEADBEEF to 0x10, then read 0x10. Each response arrives 3 cycles after the request is sampled; mem_read_val[0]=0xDEADBEEF.
- Contention: ports 0 and 1 request reads in the same cycle after reset. Port 0 responds first and port 1 responds LATENCY+2 cycles later. Repeat and confirm grants alternate 0,1,0,1.
- Aliasing and alignment, DEPTH_LOG2=10: write 0x11111111 to 0x0000_0004, read 0x0000_1007. Returns 0x11111111.
- Read+write same port: word holds 0xA5A5A5A5; issue read+write with 0x5A5A5A5A. Response returns 0xA5A5A5A5; a subsequent read returns 0x5A5A5A5A.
- Reset mid-ACCESS: write 0x12345678 to 0x20 with LATENCY=4, assert reset=0 two cycles after grant. No mem_response, all outputs 0. After release, read 0x20 returns the prior contents.
- Isolation: port 1 reads 0xCAFEF00D. Port 0 then performs a write; mem_read_val[1] stays 0xCAFEF00D and mem_response[1] stays 0.

Source files
------------

// File: rtl/multi_port_memory.sv
// multi_port_memory: round-robin arbiter that shares one word-organised RAM
// between NUM_PORTS requesters using the core's enable/value/response
// handshake. Every access takes LATENCY wait cycles between grant and array
// access, then a single response cycle; the FSM serves one port at a time.
module multi_port_memory #(
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] mem_addr,
    input  logic [NUM_PORTS-1:0]            mem_write_en,
    input  logic [NUM_PORTS-1:0]            mem_read_en,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] mem_write_val,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] mem_read_val,
    output logic [NUM_PORTS-1:0]            mem_response,
    output logic                            busy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESPOND
    } state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [PW-1:0]           grant;
    logic [PW-1:0]           last_grant;
    logic [DEPTH_LOG2-1:0]   lat_word;
    logic                    lat_we;
    logic                    lat_re;
    logic [DATA_WIDTH-1:0]   lat_wdata;

    logic [NUM_PORTS-1:0]    req;
    logic                    arb_valid;
    logic [PW-1:0]           arb_idx;
    logic [PW-1:0]           cand;
    logic                    array_op;

    logic [DATA_WIDTH-1:0]   ram [DEPTH];

    assign req      = mem_read_en | mem_write_en;
    assign busy     = (state != IDLE);
    assign array_op = (state == ACCESS) && (cnt == '0);

    // Round-robin pick: scan ports starting one past the last granted port.
    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        arb_valid = 1'b0;
        arb_idx   = '0;
        cand      = last_grant;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand = (cand == PW'(NUM_PORTS - 1)) ? '0 : cand + 1'b1;
            if (!arb_valid && req[cand]) begin
                arb_valid = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    // Transaction FSM: latch the granted request, count down the latency,
    // perform the read capture and raise the granted port's response.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            grant        <= '0;
            last_grant   <= PW'(NUM_PORTS - 1);
            lat_word     <= '0;
            lat_we       <= 1'b0;
            lat_re       <= 1'b0;
            lat_wdata    <= '0;
            mem_response <= '0;
            mem_read_val <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        grant     <= arb_idx;
                        lat_word  <= mem_addr[arb_idx*ADDR_WIDTH + 2 +: DEPTH_LOG2];
                        lat_we    <= mem_write_en[arb_idx];
                        lat_re    <= mem_read_en[arb_idx];
                        lat_wdata <= mem_write_val[arb_idx*DATA_WIDTH +: DATA_WIDTH];
                        cnt       <= CW'(LATENCY - 1);
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        // The RAM write lands on this same edge, so a
                        // read+write returns the pre-write word.
                        if (lat_re) begin
                            mem_read_val[grant*DATA_WIDTH +: DATA_WIDTH] <= ram[lat_word];
                        end
                        mem_response[grant] <= 1'b1;
                        state               <= RESPOND;
                    end
                end
                RESPOND: begin
                    mem_response <= '0;
                    last_grant   <= grant;
                    state        <= IDLE;
                end
                default: begin
                    mem_response <= '0;
                    state        <= IDLE;
                end
            endcase
        end
    end

    // Array write at the access edge; a reset earlier in the transaction
    // returns the FSM to IDLE, so an abandoned write never reaches the RAM.
    // NOTE: the RAM array is deliberately not reset so it maps onto plain memory macros.
    always_ff @(posedge clk) begin
        if (array_op && lat_we) begin
            ram[lat_word] <= lat_wdata;
        end
    end

endmodule
